dmem_access_ctrl: RTL and testbench

- Sequences MEM-stage data-memory accesses between the EX/MEM control bundle and a variable-latency data-memory port.
- Generates byte lanes for stores and extracts/sign-extends loads (big-endian).
- Holds the LL/SC link state.
- Drives StallController so the pipeline freezes until the access completes.

---
 rtl/dmem_access_ctrl.sv | 242 ++++++++++++++++++++++++
 tb/tb_dmem_access_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory sequencer: alignment check, big-endian lane steering/load extraction, LL/SC link.
// Latency >= 2 stalled cycles (IDLE, ACCESS) then DONE; waits on mem_ready, holds DONE while Stall is high.
module dmem_access_ctrl #(
   parameter int MAX_WAIT = 255,
   parameter int WAIT_W   = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        Stall,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic        MemHalf,
   input  logic        MemByte,
   input  logic        MemSignExtend,
   input  logic        LLSC,
   input  logic        LLClear,
   input  logic [31:0] ALUResult,
   input  logic [31:0] ReadData2,
   output logic [31:0] MemReadData,
   output logic        StallController,
   output logic        AddrError,
   output logic        BusError,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

   localparam bit                TO_EN   = (MAX_WAIT != 0);
   localparam logic [WAIT_W-1:0] MAX_CNT = WAIT_W'(MAX_WAIT);

   state_t            state_q, state_d;
   logic [WAIT_W-1:0] cnt_q, cnt_d;
   logic [31:0]       addr_q, addr_d;
   logic [3:0]        be_q, be_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              we_q, we_d;
   logic              byte_q, byte_d;
   logic              half_q, half_d;
   logic              sext_q, sext_d;
   logic              llsc_q, llsc_d;
   logic [1:0]        off_q, off_d;
   logic [31:0]       result_q, result_d;
   logic              llbit_q, llbit_d;
   logic [31:0]       lladdr_q, lladdr_d;

   logic        req, misalign, illegal, start, sc_fail, timeout;
   logic [31:0] word_addr, load_fmt, wdata_new;
   logic [3:0]  be_new;
   logic [7:0]  bsel;
   logic [15:0] hsel;

   assign MemReadData = result_q;

   always_comb begin
      word_addr = {ALUResult[31:2], 2'b00};
      req       = MemRead | MemWrite;
      if (MemByte)
         misalign = 1'b0;
      else if (MemHalf)
         misalign = ALUResult[0];
      else
         misalign = |ALUResult[1:0];
      illegal = (MemRead & MemWrite) | misalign;
      start   = (state_q == S_IDLE) & req & ~illegal;
      // A coincident LLClear kills the SC before it can reach memory.
      sc_fail = MemWrite & LLSC & (~llbit_q | (word_addr != lladdr_q) | LLClear);
      timeout = TO_EN & (cnt_q == MAX_CNT) & ~mem_ready;
   end

   always_comb begin
      be_new    = 4'b0000;
      wdata_new = ReadData2;
      if (MemWrite) begin
         if (MemByte) begin
            be_new    = 4'b1000 >> ALUResult[1:0];
            wdata_new = {4{ReadData2[7:0]}};
         end else if (MemHalf) begin
            be_new    = ALUResult[1] ? 4'b0011 : 4'b1100;
            wdata_new = {2{ReadData2[15:0]}};
         end else begin
            be_new    = 4'b1111;
         end
      end
   end

   always_comb begin
      case (off_q)
         2'd0:    bsel = mem_rdata[31:24];
         2'd1:    bsel = mem_rdata[23:16];
         2'd2:    bsel = mem_rdata[15:8];
         default: bsel = mem_rdata[7:0];
      endcase
      hsel = off_q[1] ? mem_rdata[15:0] : mem_rdata[31:16];
      if (byte_q)
         load_fmt = {{24{sext_q & bsel[7]}}, bsel};
      else if (half_q)
         load_fmt = {{16{sext_q & hsel[15]}}, hsel};
      else
         load_fmt = mem_rdata;
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      addr_d   = addr_q;
      be_d     = be_q;
      wdata_d  = wdata_q;
      we_d     = we_q;
      byte_d   = byte_q;
      half_d   = half_q;
      sext_d   = sext_q;
      llsc_d   = llsc_q;
      off_d    = off_q;
      result_d = result_q;
      llbit_d  = llbit_q;
      lladdr_d = lladdr_q;

      StallController = 1'b0;
      AddrError       = 1'b0;
      BusError        = 1'b0;
      mem_req         = 1'b0;
      mem_we          = 1'b0;
      mem_addr        = 32'd0;
      mem_be          = 4'd0;
      mem_wdata       = 32'd0;

      case (state_q)
         S_IDLE: begin
            AddrError = req & illegal;
            if (start) begin
               StallController = 1'b1;
               addr_d  = word_addr;
               be_d    = be_new;
               wdata_d = wdata_new;
               we_d    = MemWrite;
               byte_d  = MemByte;
               half_d  = MemHalf & ~MemByte;
               sext_d  = MemSignExtend;
               llsc_d  = LLSC;
               off_d   = ALUResult[1:0];
               cnt_d   = '0;
               if (sc_fail) begin
                  result_d = 32'd0;
                  state_d  = S_DONE;
               end else begin
                  state_d  = S_ACCESS;
               end
            end
         end
         S_ACCESS: begin
            StallController = 1'b1;
            mem_req   = 1'b1;
            mem_we    = we_q;
            mem_addr  = addr_q;
            mem_be    = be_q;
            mem_wdata = wdata_q;
            if (mem_ready) begin
               state_d = S_DONE;
               if (!we_q)
                  result_d = load_fmt;
               else if (llsc_q)
                  result_d = 32'd1;
               else
                  result_d = 32'd0;
               if (!we_q && llsc_q) begin
                  llbit_d  = 1'b1;
                  lladdr_d = addr_q;
               end else if (we_q && (llsc_q || (addr_q == lladdr_q))) begin
                  llbit_d  = 1'b0;
               end
            end else if (timeout) begin
               BusError = 1'b1;
               result_d = 32'd0;
               state_d  = S_DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DONE: begin
            if (!Stall)
               state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (LLClear)
         llbit_d = 1'b0;

      // Outputs are forced quiet for as long as reset is held.
      if (reset) begin
         StallController = 1'b0;
         AddrError       = 1'b0;
         BusError        = 1'b0;
         mem_req         = 1'b0;
         mem_we          = 1'b0;
         mem_addr        = 32'd0;
         mem_be          = 4'd0;
         mem_wdata       = 32'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         addr_q   <= 32'd0;
         be_q     <= 4'd0;
         wdata_q  <= 32'd0;
         we_q     <= 1'b0;
         byte_q   <= 1'b0;
         half_q   <= 1'b0;
         sext_q   <= 1'b0;
         llsc_q   <= 1'b0;
         off_q    <= 2'd0;
         result_q <= 32'd0;
         llbit_q  <= 1'b0;
         lladdr_q <= 32'd0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         addr_q   <= addr_d;
         be_q     <= be_d;
         wdata_q  <= wdata_d;
         we_q     <= we_d;
         byte_q   <= byte_d;
         half_q   <= half_d;
         sext_q   <= sext_d;
         llsc_q   <= llsc_d;
         off_q    <= off_d;
         result_q <= result_d;
         llbit_q  <= llbit_d;
         lladdr_q <= lladdr_d;
      end
   end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: directed scenarios plus randomized ops against a behavioural LL/SC + lane model.
module tb_dmem_access_ctrl;
   localparam int MAX_WAIT = 4;

   logic        clk = 1'b0;
   logic        reset, Stall, MemRead, MemWrite, MemHalf, MemByte, MemSignExtend, LLSC, LLClear;
   logic [31:0] ALUResult, ReadData2, MemReadData, mem_addr, mem_wdata, mem_rdata;
   logic        StallController, AddrError, BusError, mem_req, mem_we, mem_ready;
   logic [3:0]  mem_be;

   int n_checks = 0;
   int n_fail   = 0;

   dmem_access_ctrl #(.MAX_WAIT(MAX_WAIT), .WAIT_W(8)) dut (
      .clk(clk), .reset(reset), .Stall(Stall), .MemRead(MemRead), .MemWrite(MemWrite),
      .MemHalf(MemHalf), .MemByte(MemByte), .MemSignExtend(MemSignExtend), .LLSC(LLSC),
      .LLClear(LLClear), .ALUResult(ALUResult), .ReadData2(ReadData2), .MemReadData(MemReadData),
      .StallController(StallController), .AddrError(AddrError), .BusError(BusError),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
      .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // What the last run_op observed.
   int          o_stall, o_req, o_bus, o_bus_at, o_ae, o_extra;
   bit          o_done, o_unstable, o_we;
   logic [3:0]  o_be;
   logic [31:0] o_wdata, o_addr, o_res;

   // Reference link state.
   bit          m_llbit;
   logic [31:0] m_lladdr;

   function automatic logic [31:0] ref_load(logic [31:0] w, logic [31:0] a, bit b, bit h, bit sx);
      int unsigned off = a % 4;
      int unsigned sh, nbits;
      logic [31:0] mask, v;
      if (b) begin sh = (3 - off) * 8; nbits = 8; end
      else if (h) begin sh = (2 - off) * 8; nbits = 16; end
      else return w;
      mask = (32'd1 << nbits) - 32'd1;
      v = (w >> sh) & mask;
      if (sx && v[nbits-1]) v = v | ~mask;
      return v;
   endfunction

   function automatic logic [3:0] ref_be(logic [31:0] a, bit b, bit h);
      int unsigned off = a % 4;
      int unsigned v;
      if (b) v = 1 << (3 - off);
      else if (h) v = 3 << (2 - off);
      else v = 15;
      return v[3:0];
   endfunction

   function automatic logic [31:0] ref_wdata(logic [31:0] d, bit b, bit h);
      if (b) return {24'd0, d[7:0]} * 32'h01010101;
      if (h) return {16'd0, d[15:0]} * 32'h00010001;
      return d;
   endfunction

   function automatic bit ref_misaligned(logic [31:0] a, bit b, bit h);
      if (b) return 1'b0;
      if (h) return (a % 2) != 0;
      return (a % 4) != 0;
   endfunction

   task automatic clear_inputs();
      MemRead = 0; MemWrite = 0; MemHalf = 0; MemByte = 0; MemSignExtend = 0;
      LLSC = 0; LLClear = 0; Stall = 0; mem_ready = 0;
   endtask

   // Presents one op, plays a memory with 'lat' wait cycles, records what the DUT did.
   task automatic run_op(input bit rd, input bit wr, input bit h, input bit b, input bit sx,
                         input bit ll, input bit clr, input logic [31:0] a, input logic [31:0] d,
                         input int lat, input logic [31:0] rdata, input int stall_done);
      int acc;
      bit prev_stall;
      o_stall = 0; o_req = 0; o_bus = 0; o_bus_at = -1; o_ae = 0; o_extra = 0;
      o_done = 0; o_unstable = 0; o_we = 0; o_be = 0; o_wdata = 0; o_addr = 0; o_res = 0;
      acc = 0; prev_stall = 0;
      @(negedge clk);
      MemRead = rd; MemWrite = wr; MemHalf = h; MemByte = b; MemSignExtend = sx;
      LLSC = ll; LLClear = clr; ALUResult = a; ReadData2 = d; Stall = (stall_done > 0);
      for (int c = 0; c < 40; c++) begin
         if (c > 0) @(negedge clk);
         if (c == 1) LLClear = 0;
         mem_ready = mem_req && (acc == lat);
         mem_rdata = mem_ready ? rdata : $urandom;
         #1;
         if (AddrError) o_ae++;
         if (BusError) begin o_bus++; o_bus_at = acc; end
         if (mem_req) begin
            if (acc == 0) begin
               o_we = mem_we; o_be = mem_be; o_wdata = mem_wdata; o_addr = mem_addr;
            end else if (o_we !== mem_we || o_be !== mem_be || o_wdata !== mem_wdata || o_addr !== mem_addr) begin
               o_unstable = 1;
            end
            acc++;
            o_req++;
         end
         if (StallController) o_stall++;
         if (prev_stall && !StallController) begin
            o_done = 1;
            o_res = MemReadData;
            for (int k = 1; k <= stall_done; k++) begin
               @(negedge clk);
               if (k == stall_done) Stall = 0;
               mem_ready = 0;
               #1;
               if (mem_req || StallController) o_extra++;
               if (MemReadData !== o_res) o_unstable = 1;
            end
            break;
         end
         if (c >= 2 && !StallController && !prev_stall) break;
         prev_stall = StallController;
      end
      @(negedge clk);
      clear_inputs();
      #1;
      if (mem_req || StallController) o_extra++;
   endtask

   task automatic test_reset();
      clear_inputs();
      ALUResult = 0; ReadData2 = 0; mem_rdata = 0;
      reset = 1;
      repeat (3) @(negedge clk);
      MemRead = 1; ALUResult = 32'h100;
      #1;
      n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
      n_checks++; if (StallController !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", StallController); end
      n_checks++; if (MemReadData !== 32'd0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", MemReadData); end
      @(negedge clk);
      MemRead = 0; reset = 0;
      #1;
      n_checks++; if ({mem_req, mem_we, mem_be, AddrError, BusError, StallController} !== 9'd0) begin
         n_fail++; $display("FAIL reset_outputs: got %b want 0", {mem_req, mem_we, mem_be, AddrError, BusError, StallController}); end
   endtask

   task automatic test_load();
      run_op(1, 0, 0, 0, 0, 0, 0, 32'h100, 0, 0, 32'h11223344, 0);
      n_checks++; if (o_stall !== 2) begin n_fail++; $display("FAIL lw_stall_cycles: got %0d want 2", o_stall); end
      n_checks++; if (o_res !== 32'h11223344) begin n_fail++; $display("FAIL lw_data: got %h want 11223344", o_res); end
      n_checks++; if (o_be !== 4'b0000 || o_req !== 1) begin n_fail++; $display("FAIL lw_be_req: got be=%b req=%0d want 0000/1", o_be, o_req); end
      n_checks++; if (o_addr !== 32'h100) begin n_fail++; $display("FAIL lw_addr: got %h want 100", o_addr); end
      run_op(1, 0, 0, 1, 1, 0, 0, 32'h103, 0, 1, 32'h000000F0, 0);
      n_checks++; if (o_res !== 32'hFFFFFFF0) begin n_fail++; $display("FAIL lb_sext: got %h want fffffff0", o_res); end
      run_op(1, 0, 1, 0, 0, 0, 0, 32'h102, 0, 2, 32'h1234ABCD, 0);
      n_checks++; if (o_res !== 32'h0000ABCD) begin n_fail++; $display("FAIL lhu: got %h want 0000abcd", o_res); end
   endtask

   task automatic test_store();
      run_op(0, 1, 0, 1, 0, 0, 0, 32'h201, 32'h000000A5, 0, 0, 0);
      n_checks++; if (o_be !== 4'b0100) begin n_fail++; $display("FAIL sb_be: got %b want 0100", o_be); end
      n_checks++; if (o_wdata !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL sb_wdata: got %h want a5a5a5a5", o_wdata); end
      n_checks++; if (o_addr !== 32'h200 || o_we !== 1'b1) begin n_fail++; $display("FAIL sb_addr_we: got %h/%b want 200/1", o_addr, o_we); end
      run_op(0, 1, 1, 0, 0, 0, 0, 32'h202, 32'h0000BEEF, 1, 0, 0);
      n_checks++; if (o_be !== 4'b0011 || o_wdata !== 32'hBEEFBEEF) begin n_fail++; $display("FAIL sh_lanes: got %b/%h want 0011/beefbeef", o_be, o_wdata); end
   endtask

   task automatic test_llsc();
      run_op(1, 0, 0, 0, 0, 1, 0, 32'h300, 0, 0, 32'h5, 0);
      run_op(0, 1, 0, 0, 0, 1, 0, 32'h300, 32'h77, 1, 0, 0);
      n_checks++; if (o_res !== 32'd1) begin n_fail++; $display("FAIL sc_ok_status: got %h want 1", o_res); end
      n_checks++; if (o_req !== 2 || o_we !== 1'b1 || o_be !== 4'hF) begin n_fail++; $display("FAIL sc_ok_write: got req=%0d we=%b be=%b want 2/1/1111", o_req, o_we, o_be); end
      run_op(0, 1, 0, 0, 0, 1, 0, 32'h300, 32'h77, 0, 0, 0);
      n_checks++; if (o_res !== 32'd0 || o_req !== 0) begin n_fail++; $display("FAIL sc_repeat: got res=%h req=%0d want 0/0", o_res, o_req); end
      n_checks++; if (o_stall !== 1 || !o_done) begin n_fail++; $display("FAIL sc_fail_stall: got %0d want 1", o_stall); end
      run_op(1, 0, 0, 0, 0, 1, 0, 32'h300, 0, 0, 32'h5, 0);
      run_op(0, 0, 0, 0, 0, 0, 1, 32'h0, 0, 0, 0, 0);
      run_op(0, 1, 0, 0, 0, 1, 0, 32'h300, 32'h77, 0, 0, 0);
      n_checks++; if (o_res !== 32'd0 || o_req !== 0) begin n_fail++; $display("FAIL sc_after_llclear: got res=%h req=%0d want 0/0", o_res, o_req); end
      run_op(1, 0, 0, 0, 0, 1, 0, 32'h300, 0, 0, 32'h5, 0);
      run_op(0, 1, 0, 0, 0, 1, 1, 32'h300, 32'h77, 0, 0, 0);
      n_checks++; if (o_res !== 32'd0 || o_req !== 0) begin n_fail++; $display("FAIL sc_with_llclear: got res=%h req=%0d want 0/0", o_res, o_req); end
      run_op(1, 0, 0, 0, 0, 1, 0, 32'h300, 0, 0, 32'h5, 0);
      run_op(0, 1, 0, 1, 0, 0, 0, 32'h302, 32'h1, 0, 0, 0);
      run_op(0, 1, 0, 0, 0, 1, 0, 32'h300, 32'h77, 0, 0, 0);
      n_checks++; if (o_res !== 32'd0 || o_req !== 0) begin n_fail++; $display("FAIL sc_after_store: got res=%h req=%0d want 0/0", o_res, o_req); end
   endtask

   task automatic test_addr_error();
      run_op(1, 0, 0, 0, 0, 0, 0, 32'h102, 0, 0, 0, 0);
      n_checks++; if (o_ae == 0 || o_req !== 0 || o_stall !== 0) begin n_fail++; $display("FAIL lw_misaligned: got ae=%0d req=%0d stall=%0d want >0/0/0", o_ae, o_req, o_stall); end
      run_op(0, 1, 1, 0, 0, 0, 0, 32'h201, 0, 0, 0, 0);
      n_checks++; if (o_ae == 0 || o_req !== 0 || o_stall !== 0) begin n_fail++; $display("FAIL sh_misaligned: got ae=%0d req=%0d stall=%0d want >0/0/0", o_ae, o_req, o_stall); end
      run_op(1, 1, 0, 0, 0, 0, 0, 32'h100, 0, 0, 0, 0);
      n_checks++; if (o_ae == 0 || o_req !== 0) begin n_fail++; $display("FAIL rd_and_wr: got ae=%0d req=%0d want >0/0", o_ae, o_req); end
   endtask

   task automatic test_timeout();
      run_op(1, 0, 0, 0, 0, 0, 0, 32'h500, 0, 1000, 0, 0);
      n_checks++; if (o_bus !== 1 || o_bus_at !== MAX_WAIT) begin n_fail++; $display("FAIL bus_error_pulse: got count=%0d at=%0d want 1/%0d", o_bus, o_bus_at, MAX_WAIT); end
      n_checks++; if (o_req !== MAX_WAIT + 1 || o_stall !== MAX_WAIT + 2) begin n_fail++; $display("FAIL timeout_cycles: got req=%0d stall=%0d want %0d/%0d", o_req, o_stall, MAX_WAIT + 1, MAX_WAIT + 2); end
      n_checks++; if (o_res !== 32'd0 || !o_done) begin n_fail++; $display("FAIL timeout_data: got %h done=%b want 0/1", o_res, o_done); end
   endtask

   task automatic test_stall_done();
      run_op(1, 0, 0, 0, 0, 0, 0, 32'h600, 0, 0, 32'hCAFEF00D, 3);
      n_checks++; if (o_req !== 1 || o_extra !== 0) begin n_fail++; $display("FAIL stall_single_txn: got req=%0d extra=%0d want 1/0", o_req, o_extra); end
      n_checks++; if (o_res !== 32'hCAFEF00D || o_unstable) begin n_fail++; $display("FAIL stall_hold_data: got %h unstable=%b want cafef00d/0", o_res, o_unstable); end
   endtask

   task automatic test_reset_mid_access();
      run_op(1, 0, 0, 0, 0, 1, 0, 32'h300, 0, 0, 32'h9, 0);
      @(negedge clk);
      MemRead = 1; ALUResult = 32'h700; mem_ready = 0;
      @(negedge clk);
      #1;
      n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL mid_access_entry: got %b want 1", mem_req); end
      reset = 1;
      @(negedge clk);
      clear_inputs();
      reset = 0;
      #1;
      n_checks++; if (mem_req !== 1'b0 || StallController !== 1'b0) begin n_fail++; $display("FAIL reset_mid_access: got req=%b stall=%b want 0/0", mem_req, StallController); end
      @(negedge clk);
      #1;
      n_checks++; if (mem_req !== 1'b0 || MemReadData !== 32'd0) begin n_fail++; $display("FAIL reset_mid_after: got req=%b data=%h want 0/0", mem_req, MemReadData); end
      run_op(0, 1, 0, 0, 0, 1, 0, 32'h300, 32'h1, 0, 0, 0);
      n_checks++; if (o_res !== 32'd0 || o_req !== 0) begin n_fail++; $display("FAIL reset_clears_link: got res=%h req=%0d want 0/0", o_res, o_req); end
      m_llbit = 0; m_lladdr = 0;
   endtask

   task automatic test_random();
      for (int i = 0; i < 150; i++) begin
         int kind, lat, sd;
         bit rd, wr, h, b, sx, ll, clr, bad, sc_ok;
         logic [31:0] a, d, rdata, word;
         kind = $urandom_range(0, 10);
         case ($urandom_range(0, 3))
            0: a = 32'h300;
            1: a = 32'h304;
            2: a = 32'h400;
            default: a = $urandom & 32'hFFFFFFFC;
         endcase
         if ($urandom_range(0, 1) == 1) a = a | 32'($urandom_range(0, 3));
         d = $urandom; rdata = $urandom;
         lat = $urandom_range(0, 3); sd = $urandom_range(0, 2);
         clr = ($urandom_range(0, 15) == 0);
         rd = (kind <= 4) || kind == 8 || kind == 10;
         wr = (kind >= 5 && kind <= 7) || kind == 9 || kind == 10;
         h  = (kind == 1 || kind == 2 || kind == 6);
         b  = (kind == 3 || kind == 4 || kind == 7);
         sx = (kind == 1 || kind == 3);
         ll = (kind == 8 || kind == 9);
         word = a & 32'hFFFFFFFC;
         bad = (rd && wr) || ref_misaligned(a, b, h);
         sc_ok = m_llbit && (word == m_lladdr) && !clr;
         run_op(rd, wr, h, b, sx, ll, clr, a, d, lat, rdata, sd);
         if (bad) begin
            n_checks++; if (o_ae == 0 || o_req !== 0 || o_stall !== 0) begin n_fail++; $display("FAIL rnd_illegal[%0d]: got ae=%0d req=%0d stall=%0d want >0/0/0", i, o_ae, o_req, o_stall); end
         end else if (wr && ll && !sc_ok) begin
            n_checks++; if (o_res !== 32'd0 || o_req !== 0 || o_stall !== 1) begin n_fail++; $display("FAIL rnd_sc_fail[%0d]: got res=%h req=%0d stall=%0d want 0/0/1", i, o_res, o_req, o_stall); end
         end else begin
            n_checks++; if (!o_done || o_req !== lat + 1 || o_stall !== lat + 2) begin n_fail++; $display("FAIL rnd_timing[%0d]: got done=%b req=%0d stall=%0d want 1/%0d/%0d", i, o_done, o_req, o_stall, lat + 1, lat + 2); end
            n_checks++; if (o_ae !== 0 || o_bus !== 0 || o_extra !== 0 || o_unstable) begin n_fail++; $display("FAIL rnd_protocol[%0d]: got ae=%0d bus=%0d extra=%0d unstable=%b want 0/0/0/0", i, o_ae, o_bus, o_extra, o_unstable); end
            n_checks++; if (o_addr !== word || o_we !== wr) begin n_fail++; $display("FAIL rnd_addr_we[%0d]: got %h/%b want %h/%b", i, o_addr, o_we, word, wr); end
            if (rd) begin
               n_checks++; if (o_res !== ref_load(rdata, a, b, h, sx) || o_be !== 4'd0) begin n_fail++; $display("FAIL rnd_load[%0d]: got %h be=%b want %h be=0000", i, o_res, o_be, ref_load(rdata, a, b, h, sx)); end
            end else begin
               n_checks++; if (o_be !== ref_be(a, b, h) || o_wdata !== ref_wdata(d, b, h)) begin n_fail++; $display("FAIL rnd_store[%0d]: got %b/%h want %b/%h", i, o_be, o_wdata, ref_be(a, b, h), ref_wdata(d, b, h)); end
               if (ll) begin
                  n_checks++; if (o_res !== 32'd1) begin n_fail++; $display("FAIL rnd_sc_ok[%0d]: got %h want 1", i, o_res); end
               end
            end
         end
         if (clr) m_llbit = 0;
         if (!bad) begin
            if (rd && ll) begin m_llbit = 1; m_lladdr = word; end
            else if (wr && ll && sc_ok) m_llbit = 0;
            else if (wr && !ll && word == m_lladdr) m_llbit = 0;
         end
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      reset = 1;
      ALUResult = 0; ReadData2 = 0; mem_rdata = 0;
      clear_inputs();
      m_llbit = 0; m_lladdr = 0;
      test_reset();
      test_load();
      test_store();
      test_llsc();
      test_addr_error();
      test_timeout();
      test_stall_done();
      test_reset_mid_access();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
